snn_timestep_controller: RTL and testbench

//  Sequences the event-driven neuron datapath through a configured number of timesteps. Each

---
 rtl/snn_timestep_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_snn_timestep_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_controller.sv
// snn_timestep_controller
//   Sequences the event-driven neuron datapath through N timesteps. Each
//   timestep has a spike-injection phase followed by a leak/update phase.
//   Control and configuration come from the AXI-lite register block. Status
//   and the spike count are returned to that block for readback.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   ctrl_reg      [0] run enable (rising edge starts a run), [1] soft clear
//   config_reg    [15:0] number of timesteps N (latched at start)
//   inject_start  1-cycle pulse: injector drains events for this timestep
//   inject_done   1-cycle pulse from the injector
//   leak_start    1-cycle pulse: neuron array applies leak/refractory update
//   leak_done     1-cycle pulse from the neuron array
//   spike_event   one output spike this cycle
//   timestep_idx  0-based index of the timestep in progress
//   status_reg    [0] busy [1] done [2] timeout error [5:3] state [31:16] idx
//   spike_count   saturating count of output spikes seen while busy
//   irq           1-cycle pulse on entry to DONE or ERROR
module snn_timestep_controller #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ctrl_reg,
  input  logic [31:0]      config_reg,
  output logic             inject_start,
  input  logic             inject_done,
  output logic             leak_start,
  input  logic             leak_done,
  input  logic             spike_event,
  output logic [15:0]      timestep_idx,
  output logic [31:0]      status_reg,
  output logic [CNT_W-1:0] spike_count,
  output logic             irq
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INJECT    = 3'd1,
    S_WAIT_INJ  = 3'd2,
    S_LEAK      = 3'd3,
    S_WAIT_LEAK = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [15:0]      num_ts_q;
  logic [15:0]      idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, err_q, irq_q;
  logic [TMO_W-1:0] tmo_q;
  logic             inj_seen_q, leak_seen_q;

  logic             start_s, clr_s, busy_s, abort_s, tmo_hit_s;
  logic             launch_s, launch_nz_s, waiting_s;
  logic [2:0]       state_code_s;
  logic             unused_s;

  assign start_s     = ctrl_reg[0] & ~run_q;
  assign clr_s       = ctrl_reg[1];
  assign abort_s     = busy_s & ~ctrl_reg[0];
  assign tmo_hit_s   = (tmo_q == TMO_LAST);
  // A start is only accepted from IDLE; soft clear suppresses it.
  assign launch_s    = (state_q == S_IDLE) & start_s & ~clr_s;
  assign launch_nz_s = launch_s & (config_reg[15:0] != 16'd0);
  assign waiting_s   = (state_q == S_WAIT_INJ) | (state_q == S_WAIT_LEAK);
  assign unused_s    = ^{ctrl_reg[31:2], config_reg[31:16]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: soft clear, then abort, then normal sequencing.
  always_comb begin
    state_d = state_q;
    if (clr_s) begin
      state_d = S_IDLE;
    end else if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_d = (config_reg[15:0] == 16'd0) ? S_DONE : S_INJECT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INJECT: state_d = S_WAIT_INJ;
        S_WAIT_INJ: begin
          // A done pulse that arrived during INJECT was latched.
          if (inject_done | inj_seen_q) begin
            state_d = S_LEAK;
          end else if (tmo_hit_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_WAIT_INJ;
          end
        end
        S_LEAK: state_d = S_WAIT_LEAK;
        S_WAIT_LEAK: begin
          if (leak_done | leak_seen_q) begin
            state_d = S_NEXT;
          end else if (tmo_hit_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_WAIT_LEAK;
          end
        end
        S_NEXT: begin
          if (idx_q == (num_ts_q - 16'd1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_INJECT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    inject_start = 1'b0;
    leak_start   = 1'b0;
    busy_s       = 1'b0;
    case (state_q)
      S_INJECT:    begin inject_start = 1'b1; busy_s = 1'b1; end
      S_WAIT_INJ:  busy_s = 1'b1;
      S_LEAK:      begin leak_start = 1'b1; busy_s = 1'b1; end
      S_WAIT_LEAK: busy_s = 1'b1;
      S_NEXT:      busy_s = 1'b1;
      default:     busy_s = 1'b0;
    endcase
  end

  // Datapath: edge detect, phase latches, timeout, index, count, flags, irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= 1'b0;
      inj_seen_q  <= 1'b0;
      leak_seen_q <= 1'b0;
      irq_q       <= 1'b0;
      tmo_q       <= '0;
      num_ts_q    <= 16'd0;
      idx_q       <= 16'd0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      run_q       <= ctrl_reg[0];
      inj_seen_q  <= (state_q == S_INJECT) & inject_done;
      leak_seen_q <= (state_q == S_LEAK) & leak_done;
      // DONE/ERROR are only ever entered, never held, so this is an entry pulse.
      irq_q       <= (state_d == S_DONE) | (state_d == S_ERROR);

      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if (waiting_s) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end

      if (launch_s) begin
        num_ts_q <= config_reg[15:0];
      end

      if (clr_s) begin
        idx_q  <= 16'd0;
        cnt_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (launch_nz_s) begin
          idx_q <= 16'd0;
        end else if ((state_q == S_NEXT) && (state_d == S_INJECT)) begin
          idx_q <= idx_q + 16'd1;
        end

        if (launch_nz_s) begin
          cnt_q <= '0;
        end else if (busy_s && spike_event && !(&cnt_q)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end

        if (abort_s) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end else if (launch_s) begin
          done_q <= (config_reg[15:0] == 16'd0);
          err_q  <= 1'b0;
        end else begin
          if (state_d == S_DONE)  done_q <= 1'b1;
          if (state_d == S_ERROR) err_q  <= 1'b1;
        end
      end
    end
  end

  assign state_code_s = state_q;
  assign timestep_idx = idx_q;
  assign spike_count  = cnt_q;
  assign irq          = irq_q;
  assign status_reg   = {idx_q, 10'd0, state_code_s, err_q, done_q, busy_s};

endmodule

// File: tb/tb_snn_timestep_controller.sv
module tb_snn_timestep_controller;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl_reg, config_reg;
  logic        inject_done, leak_done, spike_event;
  logic        a_inj, a_leak, a_irq, s_inj, s_leak, s_irq;
  logic [15:0] a_idx, s_idx, a_cnt;
  logic [31:0] a_status, s_status;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  snn_timestep_controller #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ctrl_reg(ctrl_reg), .config_reg(config_reg),
    .inject_start(a_inj), .inject_done(inject_done), .leak_start(a_leak),
    .leak_done(leak_done), .spike_event(spike_event), .timestep_idx(a_idx),
    .status_reg(a_status), .spike_count(a_cnt), .irq(a_irq));

  snn_timestep_controller #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .ctrl_reg(ctrl_reg), .config_reg(config_reg),
    .inject_start(s_inj), .inject_done(inject_done), .leak_start(s_leak),
    .leak_done(leak_done), .spike_event(spike_event), .timestep_idx(s_idx),
    .status_reg(s_status), .spike_count(s_cnt), .irq(s_irq));

  int n_tests = 0;
  int n_fail  = 0;

  // Run measurements
  int          r_inj, r_leak, r_irq, r_irq_off, r_first, r_blen, r_spk;
  logic [31:0] r_status;
  logic [15:0] r_idx, r_cnt_a;
  logic [3:0]  r_cnt_s;

  // Reference model state carried between runs
  int mdl_idx = 0;
  int mdl_cnt = 0;

  int irqs, irq_at, pulses;
  logic [31:0] st_a, st_b;

  typedef struct {
    bit          pre_clear;
    int          n;
    int          dly;
    int          spk_run;
    int          spk_idle;
    logic [31:0] exp_status;
    int          exp_cnt_a;
    int          exp_cnt_s;
    int          exp_pulses;
    int          exp_irq_off;
    int          exp_first;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // One complete run: lead-in with enable low, start, respond to phase pulses.
  task automatic do_run(input bit pre_clear, input int n, input bit rnd, input int dly,
                        input int spk_run, input int spk_idle);
    int di[16];
    int dl[16];
    int inj_wait, leak_wait, inj_ts, leak_ts;
    bit seen_irq;
    r_blen = 0;
    for (int t = 0; t < 16; t++) begin
      di[t] = rnd ? int'($urandom_range(0, 4)) : dly;
      dl[t] = rnd ? int'($urandom_range(0, 4)) : dly;
      // A timestep is INJECT + LEAK + NEXT plus at least one cycle per wait.
      if (t < n) r_blen += 3 + ((di[t] > 1) ? di[t] : 1) + ((dl[t] > 1) ? dl[t] : 1);
    end
    inject_done = 1'b0; leak_done = 1'b0; spike_event = 1'b0;
    if (pre_clear) begin
      @(negedge clk); ctrl_reg = 32'h2;
    end
    for (int i = 0; i <= spk_idle; i++) begin
      @(negedge clk); ctrl_reg = 32'h0; spike_event = (i < spk_idle);
    end
    r_inj = 0; r_leak = 0; r_irq = 0; r_irq_off = -1; r_first = -1; r_spk = 0;
    r_status = '0; r_idx = '0; r_cnt_a = '0; r_cnt_s = '0;
    inj_wait = -1; leak_wait = -1; inj_ts = 0; leak_ts = 0; seen_irq = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_inj) begin
        r_inj++;
        if (r_first < 0) r_first = c;
        if (inj_ts < 16) inj_wait = di[inj_ts];
        inj_ts++;
      end
      if (a_leak) begin
        r_leak++;
        if (leak_ts < 16) leak_wait = dl[leak_ts];
        leak_ts++;
      end
      if (a_irq) begin
        r_irq++;
        if (!seen_irq) begin
          seen_irq = 1'b1; r_irq_off = c; r_status = a_status;
          r_idx = a_idx; r_cnt_a = a_cnt; r_cnt_s = s_cnt;
        end
      end
      ctrl_reg    = 32'h1;
      config_reg  = (c == 0) ? {16'($urandom), 16'(n)} : $urandom;
      inject_done = (inj_wait == 0);
      if (inj_wait >= 0) inj_wait--;
      leak_done   = (leak_wait == 0);
      if (leak_wait >= 0) leak_wait--;
      spike_event = rnd ? 1'($urandom_range(0, 1)) : (c >= 1 && c <= spk_run);
      if (spike_event && c >= 1 && c <= r_blen) r_spk++;
      if (seen_irq && c >= r_irq_off + 2) break;
    end
    inject_done = 1'b0; leak_done = 1'b0; spike_event = 1'b0;
  endtask

  task automatic check_run(input string tag, input int e_pulses, input int e_first,
                           input int e_off, input logic [31:0] e_status,
                           input longint e_cnt_a, input longint e_cnt_s);
    chk({tag, "_inject_pulses"}, r_inj, e_pulses);
    chk({tag, "_leak_pulses"}, r_leak, e_pulses);
    chk({tag, "_first_inject"}, r_first, e_first);
    chk({tag, "_irq_cycle"}, r_irq_off, e_off);
    chk({tag, "_irq_count"}, r_irq, 1);
    chk({tag, "_status"}, r_status, e_status);
    chk({tag, "_idx"}, r_idx, e_status[31:16]);
    chk({tag, "_count16"}, r_cnt_a, e_cnt_a);
    chk({tag, "_count4"}, r_cnt_s, e_cnt_s);
  endtask

  task automatic rand_run(input string tag);
    int n;
    int e_idx;
    int e_cnt;
    n = $urandom_range(0, 6);
    do_run(1'b0, n, 1'b1, 0, 0, 0);
    // N=0 goes straight to DONE and leaves index and count untouched.
    e_idx = (n == 0) ? mdl_idx : n - 1;
    e_cnt = (n == 0) ? mdl_cnt : r_spk;
    check_run(tag, n, (n > 0) ? 1 : -1, r_blen + 1, {16'(e_idx), 16'h0032},
              sat(e_cnt, 65535), sat(e_cnt, 15));
    mdl_idx = e_idx;
    mdl_cnt = e_cnt;
  endtask

  initial begin
    //         clr  n  dly run idle status        cnt16 cnt4 pulses off first
    vecs[0] = '{1'b1, 0, 0,  0, 2, 32'h0000_0032, 0,  0,  0, 1,  -1};
    vecs[1] = '{1'b0, 4, 0, 10, 3, 32'h0003_0032, 10, 10, 4, 21, 1};
    vecs[2] = '{1'b0, 4, 0, 20, 0, 32'h0003_0032, 20, 15, 4, 21, 1};
    vecs[3] = '{1'b0, 3, 2,  0, 0, 32'h0002_0032, 0,  0,  3, 22, 1};
    vecs[4] = '{1'b0, 1, 4,  5, 1, 32'h0000_0032, 5,  5,  1, 12, 1};

    rst = 1'b1; ctrl_reg = 32'h0; config_reg = 32'h0;
    inject_done = 1'b0; leak_done = 1'b0; spike_event = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_status", a_status, 32'h0);
    chk("reset_misc", {a_cnt, a_idx, a_irq, a_inj, a_leak, s_cnt}, 0);
    rst = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].pre_clear, vecs[i].n, 1'b0, vecs[i].dly, vecs[i].spk_run, vecs[i].spk_idle);
      check_run($sformatf("vec%0d", i), vecs[i].exp_pulses, vecs[i].exp_first,
                vecs[i].exp_irq_off, vecs[i].exp_status, vecs[i].exp_cnt_a, vecs[i].exp_cnt_s);
      mdl_idx = int'(vecs[i].exp_status[31:16]);
      mdl_cnt = vecs[i].exp_cnt_a;
    end

    // Enable held high after DONE must not restart
    pulses = 0; irqs = 0; config_reg = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pulses += int'(a_inj) + int'(a_leak);
      irqs   += int'(a_irq);
    end
    chk("hold_no_restart", pulses, 0);
    chk("hold_no_irq", irqs, 0);
    chk("hold_status", a_status, {16'(mdl_idx), 16'h0002});

    // Timeout: N=2, leak_done never returned
    @(negedge clk); ctrl_reg = 32'h0;
    @(negedge clk); ctrl_reg = 32'h1; config_reg = 32'd2;
    irqs = 0; irq_at = -1; st_a = '0; st_b = '0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      inject_done = a_inj; leak_done = 1'b0;
      if (a_irq) begin
        irqs++;
        if (irq_at < 0) begin irq_at = c; st_a = a_status; end
      end
      if (c == 21) st_b = a_status;
    end
    inject_done = 1'b0;
    chk("timeout_irq_cycle", irq_at, 20);
    chk("timeout_status", st_a, 32'h0000_003C);
    chk("timeout_irq_count", irqs, 1);
    chk("timeout_sticky", st_b, 32'h0000_0004);
    mdl_idx = 0; mdl_cnt = 0;

    for (int k = 0; k < 6; k++) rand_run($sformatf("rnd%0d", k));

    // Soft clear in WAIT_INJ together with a spike
    @(negedge clk); ctrl_reg = 32'h0;
    @(negedge clk); ctrl_reg = 32'h1; config_reg = 32'd3; spike_event = 1'b0;
    @(negedge clk); spike_event = 1'b1;
    @(negedge clk);
    chk("clr_pre_status", a_status, 32'h0000_0011);
    chk("clr_pre_count", a_cnt, 1);
    ctrl_reg = 32'h3; spike_event = 1'b1;
    @(negedge clk);
    chk("clr_status", a_status, 32'h0);
    chk("clr_misc", {a_cnt, a_idx, a_irq, a_inj, s_cnt}, 0);
    ctrl_reg = 32'h1; spike_event = 1'b0;
    @(negedge clk);
    chk("clr_stays_idle", a_status, 32'h0);
    mdl_idx = 0; mdl_cnt = 0;

    for (int k = 0; k < 2; k++) rand_run($sformatf("post_clr%0d", k));

    // Enable dropped in timestep 1 WAIT_INJ
    @(negedge clk); ctrl_reg = 32'h0;
    @(negedge clk); ctrl_reg = 32'h1; config_reg = 32'd3;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      inject_done = a_inj; leak_done = a_leak; spike_event = (c <= 3);
      if (c == 7) ctrl_reg = 32'h0;
    end
    @(negedge clk);
    inject_done = 1'b0; leak_done = 1'b0;
    chk("abort_status", a_status, 32'h0001_0000);
    chk("abort_count", a_cnt, 3);
    pulses = 0; irqs = int'(a_irq);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pulses += int'(a_inj) + int'(a_leak);
      irqs   += int'(a_irq);
    end
    chk("abort_no_pulses", pulses, 0);
    chk("abort_no_irq", irqs, 0);
    mdl_idx = 1; mdl_cnt = 3;

    for (int k = 0; k < 2; k++) rand_run($sformatf("post_abort%0d", k));

    // Asynchronous reset mid-run
    @(negedge clk); ctrl_reg = 32'h0;
    @(negedge clk); ctrl_reg = 32'h1; config_reg = 32'd5;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) chk("pre_rst_count", a_cnt, 7);
      inject_done = a_inj; leak_done = a_leak; spike_event = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_async_a", {a_status, a_cnt, a_idx}, 0);
    chk("rst_async_b", {s_status, s_cnt, s_idx, a_irq, a_inj, a_leak, s_irq, s_inj, s_leak}, 0);
    @(negedge clk);
    rst = 1'b0; ctrl_reg = 32'h0; inject_done = 1'b0; leak_done = 1'b0; spike_event = 1'b0;
    mdl_idx = 0; mdl_cnt = 0;

    rand_run("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
